// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg : shared ALU widths and op-code encodings          | rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;
  localparam int XLEN  = 32;
  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [SEL_W-1:0] ALU_AND  = 4'd2;
  localparam logic [SEL_W-1:0] ALU_OR   = 4'd3;
  localparam logic [SEL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [SEL_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [SEL_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [SEL_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [SEL_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [SEL_W-1:0] ALU_SRA  = 4'd9;

  localparam int ALU_NUM_OPS = 10;
endpackage

`default_nettype wire

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu : purely combinational integer ALU with zero flag      | rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu #(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int SEL_W = alu_pkg::SEL_W
) (
  input  logic [XLEN-1:0]  i_a,
  input  logic [XLEN-1:0]  i_b,
  input  logic [SEL_W-1:0] i_sel,
  output logic [XLEN-1:0]  o_result,
  output logic             o_zero
);
  import alu_pkg::*;

  logic [4:0]      w_shamt;
  logic            w_slt;
  logic            w_sltu;
  logic [XLEN-1:0] w_result;

  assign w_shamt = i_b[4:0];
  assign w_slt   = $signed(i_a) < $signed(i_b);
  assign w_sltu  = i_a < i_b;

  // Unlisted op codes fall through to zero rather than flagging an error.
  always_comb begin
    w_result = '0;
    case (i_sel)
      ALU_ADD:  w_result = i_a + i_b;
      ALU_SUB:  w_result = i_a - i_b;
      ALU_AND:  w_result = i_a & i_b;
      ALU_OR:   w_result = i_a | i_b;
      ALU_XOR:  w_result = i_a ^ i_b;
      ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, w_slt};
      ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, w_sltu};
      ALU_SLL:  w_result = i_a << w_shamt;
      ALU_SRL:  w_result = i_a >> w_shamt;
      ALU_SRA:  w_result = $unsigned($signed(i_a) >>> w_shamt);
      default:  w_result = '0;
    endcase
  end

  assign o_result = w_result;
  assign o_zero   = (w_result == '0);
endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter : round-robin sharing of one ALU by two requesters | rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int XLEN  = alu_pkg::XLEN,
  parameter int SEL_W = alu_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [XLEN-1:0]  req_a0,
  input  logic [XLEN-1:0]  req_a1,
  input  logic [XLEN-1:0]  req_b0,
  input  logic [XLEN-1:0]  req_b1,
  input  logic [SEL_W-1:0] req_sel0,
  input  logic [SEL_W-1:0] req_sel1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [XLEN-1:0]  rsp_result0,
  output logic [XLEN-1:0]  rsp_result1,
  output logic             rsp_zero0,
  output logic             rsp_zero1
);
  import alu_pkg::*;

  logic            r_last_grant;
  logic            r_rsp_valid0, r_rsp_valid1;
  logic [XLEN-1:0] r_rsp_result0, r_rsp_result1;
  logic            r_rsp_zero0, r_rsp_zero1;

  logic             w_elig0, w_elig1;
  logic             w_gnt0, w_gnt1;
  logic [XLEN-1:0]  w_alu_a, w_alu_b, w_alu_res;
  logic [SEL_W-1:0] w_alu_sel;
  logic             w_alu_zero;

  // A slot that drains this cycle can accept a new result at the same edge.
  assign w_elig0 = req_valid0 && (!r_rsp_valid0 || rsp_ready0);
  assign w_elig1 = req_valid1 && (!r_rsp_valid1 || rsp_ready1);

  // rst_n gating keeps ready low throughout reset, not just after the first edge.
  assign w_gnt0 = rst_n && w_elig0 && (!w_elig1 || r_last_grant);
  assign w_gnt1 = rst_n && w_elig1 && (!w_elig0 || !r_last_grant);

  assign req_ready0 = w_gnt0;
  assign req_ready1 = w_gnt1;

  assign w_alu_a   = w_gnt1 ? req_a1   : req_a0;
  assign w_alu_b   = w_gnt1 ? req_b1   : req_b0;
  assign w_alu_sel = w_gnt1 ? req_sel1 : req_sel0;

  alu #(
    .XLEN  (XLEN),
    .SEL_W (SEL_W)
  ) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_sel    (w_alu_sel),
    .o_result (w_alu_res),
    .o_zero   (w_alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant  <= 1'b1;
      r_rsp_valid0  <= 1'b0;
      r_rsp_valid1  <= 1'b0;
      r_rsp_result0 <= '0;
      r_rsp_result1 <= '0;
      r_rsp_zero0   <= 1'b0;
      r_rsp_zero1   <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
        r_last_grant <= 1'b1;
      end

      if (w_gnt0) begin
        r_rsp_valid0  <= 1'b1;
        r_rsp_result0 <= w_alu_res;
        r_rsp_zero0   <= w_alu_zero;
      end else if (r_rsp_valid0 && rsp_ready0) begin
        r_rsp_valid0 <= 1'b0;
      end

      if (w_gnt1) begin
        r_rsp_valid1  <= 1'b1;
        r_rsp_result1 <= w_alu_res;
        r_rsp_zero1   <= w_alu_zero;
      end else if (r_rsp_valid1 && rsp_ready1) begin
        r_rsp_valid1 <= 1'b0;
      end
    end
  end

  assign rsp_valid0  = r_rsp_valid0;
  assign rsp_valid1  = r_rsp_valid1;
  assign rsp_result0 = r_rsp_result0;
  assign rsp_result1 = r_rsp_result1;
  assign rsp_zero0   = r_rsp_zero0;
  assign rsp_zero1   = r_rsp_zero1;
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter : directed scenarios plus a scoreboard monitor | rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [3:0]  req_sel0, req_sel1;
  logic        rsp_valid0, rsp_valid1;
  logic        rsp_ready0, rsp_ready1;
  logic [31:0] rsp_result0, rsp_result1;
  logic        rsp_zero0, rsp_zero1;

  int nt = 0;
  int nf = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        m_v0, m_v1, m_last;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .req_sel0(req_sel0), .req_sel1(req_sel1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_result0(rsp_result0), .rsp_result1(rsp_result1),
    .rsp_zero0(rsp_zero0), .rsp_zero1(rsp_zero1)
  );

  // Reference ALU: {zero, result}
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    case (s)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << sh;
      4'd8: r = a >> sh;
      4'd9: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Scoreboard: predict grants, push on grant, pop when a response is consumed.
  always @(negedge clk) begin
    logic e0, e1, g0, g1;
    logic [32:0] exp;
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_v0 = 1'b0; m_v1 = 1'b0; m_last = 1'b1;
    end else begin
      e0 = req_valid0 && (!m_v0 || rsp_ready0);
      e1 = req_valid1 && (!m_v1 || rsp_ready1);
      g0 = e0 && (!e1 || m_last);
      g1 = e1 && (!e0 || !m_last);
      nt++;
      if ({req_ready0, req_ready1} !== {g0, g1}) begin
        nf++;
        $display("FAIL sb_grant t=%0t ready=%b%b expected %b%b", $time, req_ready0, req_ready1, g0, g1);
      end
      nt++;
      if ({rsp_valid0, rsp_valid1} !== {m_v0, m_v1}) begin
        nf++;
        $display("FAIL sb_rsp_valid t=%0t got %b%b expected %b%b", $time, rsp_valid0, rsp_valid1, m_v0, m_v1);
      end
      if (m_v0 && rsp_ready0 && q0.size() > 0) begin
        exp = q0.pop_front();
        nt++;
        if ({rsp_zero0, rsp_result0} !== exp) begin
          nf++;
          $display("FAIL sb_rsp0 t=%0t got z=%b r=%h expected z=%b r=%h", $time, rsp_zero0, rsp_result0, exp[32], exp[31:0]);
        end
      end
      if (m_v1 && rsp_ready1 && q1.size() > 0) begin
        exp = q1.pop_front();
        nt++;
        if ({rsp_zero1, rsp_result1} !== exp) begin
          nf++;
          $display("FAIL sb_rsp1 t=%0t got z=%b r=%h expected z=%b r=%h", $time, rsp_zero1, rsp_result1, exp[32], exp[31:0]);
        end
      end
      if (g0) q0.push_back(alu_model(req_a0, req_b0, req_sel0));
      if (g1) q1.push_back(alu_model(req_a1, req_b1, req_sel1));
      if (g0) m_v0 = 1'b1; else if (m_v0 && rsp_ready0) m_v0 = 1'b0;
      if (g1) m_v1 = 1'b1; else if (m_v1 && rsp_ready1) m_v1 = 1'b0;
      if (g0) m_last = 1'b0; else if (g1) m_last = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    req_a0 = 0; req_b0 = 0; req_sel0 = 0;
    req_a1 = 0; req_b1 = 0; req_sel1 = 0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    #3;
    nt++;
    if ({req_ready0, req_ready1} !== 2'b00) begin
      nf++; $display("FAIL reset_req_ready got %b%b expected 00", req_ready0, req_ready1);
    end
    nt++;
    if ({rsp_valid0, rsp_valid1, rsp_zero0, rsp_zero1} !== 4'b0000) begin
      nf++; $display("FAIL reset_flags got v=%b%b z=%b%b expected 0000", rsp_valid0, rsp_valid1, rsp_zero0, rsp_zero1);
    end
    nt++;
    if (rsp_result0 !== 32'd0 || rsp_result1 !== 32'd0) begin
      nf++; $display("FAIL reset_result got %h %h expected 0 0", rsp_result0, rsp_result1);
    end
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    req_valid0 = 1'b1; req_a0 = 32'd10; req_b0 = 32'd20; req_sel0 = 4'd0;
    @(negedge clk);
    nt++;
    if (req_ready0 !== 1'b1) begin
      nf++; $display("FAIL single_ready got %b expected 1", req_ready0);
    end
    tick();
    req_valid0 = 1'b0;
    nt++;
    if (rsp_valid0 !== 1'b1 || rsp_result0 !== 32'd30 || rsp_zero0 !== 1'b0) begin
      nf++; $display("FAIL single_rsp got v=%b r=%0d z=%b expected v=1 r=30 z=0", rsp_valid0, rsp_result0, rsp_zero0);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic exp0;
    apply_reset();
    req_valid0 = 1'b1; req_a0 = 32'd20;     req_b0 = 32'd10;     req_sel0 = 4'd1;
    req_valid1 = 1'b1; req_a1 = 32'hF0F0;   req_b1 = 32'h0FF0;   req_sel1 = 4'd2;
    @(negedge clk);
    nt++;
    if ({req_ready0, req_ready1} !== 2'b10) begin
      nf++; $display("FAIL conflict_t0 got %b%b expected 10", req_ready0, req_ready1);
    end
    tick();
    req_a0 = 32'd1; req_b0 = 32'd1; req_sel0 = 4'd0;
    nt++;
    if (rsp_result0 !== 32'd10) begin
      nf++; $display("FAIL conflict_res0 got %h expected 0000000a", rsp_result0);
    end
    @(negedge clk);
    nt++;
    if ({req_ready0, req_ready1} !== 2'b01) begin
      nf++; $display("FAIL conflict_t1 got %b%b expected 01", req_ready0, req_ready1);
    end
    tick();
    req_a1 = 32'd1; req_b1 = 32'd2; req_sel1 = 4'd3;
    nt++;
    if (rsp_result1 !== 32'h00F0) begin
      nf++; $display("FAIL conflict_res1 got %h expected 000000f0", rsp_result1);
    end
    for (int k = 0; k < 4; k++) begin
      exp0 = (k % 2 == 0);
      @(negedge clk);
      nt++;
      if ({req_ready0, req_ready1} !== {exp0, ~exp0}) begin
        nf++; $display("FAIL conflict_alt%0d got %b%b expected %b%b", k, req_ready0, req_ready1, exp0, ~exp0);
      end
      tick();
      if (exp0) req_a0 = 32'd100 + k; else req_a1 = 32'd200 + k;
    end
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b1;
    req_valid0 = 1'b1; req_a0 = 32'd1; req_b0 = 32'd2; req_sel0 = 4'd0;
    tick();
    req_a0 = 32'd6; req_b0 = 32'd3; req_sel0 = 4'd4;
    req_valid1 = 1'b1; req_sel1 = 4'd0; req_b1 = 32'd100;
    for (int k = 0; k < 3; k++) begin
      req_a1 = k;
      @(negedge clk);
      nt++;
      if ({req_ready0, req_ready1} !== 2'b01) begin
        nf++; $display("FAIL bp_grant%0d got %b%b expected 01", k, req_ready0, req_ready1);
      end
      nt++;
      if (rsp_valid0 !== 1'b1 || rsp_result0 !== 32'd3) begin
        nf++; $display("FAIL bp_hold%0d got v=%b r=%0d expected v=1 r=3", k, rsp_valid0, rsp_result0);
      end
      tick();
    end
    rsp_ready0 = 1'b1;
    @(negedge clk);
    nt++;
    if (req_ready0 !== 1'b1) begin
      nf++; $display("FAIL bp_refill_ready got %b expected 1", req_ready0);
    end
    tick();
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    nt++;
    if (rsp_valid0 !== 1'b1 || rsp_result0 !== 32'd5) begin
      nf++; $display("FAIL bp_refill got v=%b r=%0d expected v=1 r=5", rsp_valid0, rsp_result0);
    end
    tick(); tick();
  endtask

  task automatic test_ops();
    logic [31:0] ta[8];
    logic [31:0] tb_[8];
    logic [3:0]  ts[8];
    logic [31:0] tr[8];
    logic        tz[8];
    ta = '{-32'sd5, -32'sd5, 32'd1,  32'hF0, -32'sd16,   32'd5, 32'd7, 32'd10};
    tb_= '{32'd3,   32'd3,   32'd4,  32'd4,  32'd2,      32'd5, 32'd9, 32'd20};
    ts = '{4'd5,    4'd6,    4'd7,   4'd8,   4'd9,       4'd1,  4'd12, 4'd0};
    tr = '{32'd1,   32'd0,   32'h10, 32'hF,  32'hFFFFFFFC, 32'd0, 32'd0, 32'd30};
    tz = '{1'b0,    1'b1,    1'b0,   1'b0,   1'b0,       1'b1,  1'b1,  1'b0};
    rsp_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid0 = 1'b1; req_a0 = ta[i]; req_b0 = tb_[i]; req_sel0 = ts[i];
      @(negedge clk);
      nt++;
      if (req_ready0 !== 1'b1) begin
        nf++; $display("FAIL ops_ready%0d got %b expected 1", i, req_ready0);
      end
      tick();
      nt++;
      if (rsp_result0 !== tr[i] || rsp_zero0 !== tz[i]) begin
        nf++; $display("FAIL ops%0d sel=%0d got r=%h z=%b expected r=%h z=%b", i, ts[i], rsp_result0, rsp_zero0, tr[i], tz[i]);
      end
    end
    req_valid0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b0;
    req_valid1 = 1'b1; req_a1 = 32'd3; req_b1 = 32'd4; req_sel1 = 4'd0;
    @(negedge clk);
    nt++;
    if (req_ready1 !== 1'b1) begin
      nf++; $display("FAIL midop_grant got %b expected 1", req_ready1);
    end
    tick();
    req_a1 = 32'd8;
    #1;
    rst_n = 1'b0;
    #1;
    nt++;
    if (rsp_valid1 !== 1'b0 || rsp_result1 !== 32'd0) begin
      nf++; $display("FAIL midop_async got v=%b r=%h expected v=0 r=0", rsp_valid1, rsp_result1);
    end
    req_valid0 = 1'b1; req_a0 = 32'd2; req_b0 = 32'd2; req_sel0 = 4'd0;
    rsp_ready1 = 1'b1;
    @(negedge clk);
    nt++;
    if ({req_ready0, req_ready1} !== 2'b00) begin
      nf++; $display("FAIL midop_ready_in_reset got %b%b expected 00", req_ready0, req_ready1);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    nt++;
    if ({req_ready0, req_ready1} !== 2'b10) begin
      nf++; $display("FAIL midop_first_grant got %b%b expected 10", req_ready0, req_ready1);
    end
    tick();
    req_valid0 = 1'b0;
    @(negedge clk);
    nt++;
    if (req_ready1 !== 1'b1) begin
      nf++; $display("FAIL midop_second_grant got %b expected 1", req_ready1);
    end
    tick();
    req_valid1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_drain();
    nt++;
    if (q0.size() != 0 || q1.size() != 0) begin
      nf++; $display("FAIL drain got q0=%0d q1=%0d pending expected 0 0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_conflict();
    test_backpressure();
    test_ops();
    test_reset_midop();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares the single combinational `alu` between two requesters, for example execute-stage integer ops and the branch/address-compare path. Each requester uses a valid/ready request channel and a registered response slot with its own backpressure. Conflicts are resolved round-robin. The block adds one cycle of latency and sustains one ALU operation per cycle in aggregate.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.
- `SEL_W`, default 4: ALU op-select width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid0` / `req_valid1`, input, 1: requester i presents an operation.
- `req_ready0` / `req_ready1`, output, 1: operation i accepted this cycle.
- `req_a0` / `req_a1`, input, XLEN: operand A.
- `req_b0` / `req_b1`, input, XLEN: operand B; shifts use `b[4:0]`.
- `req_sel0` / `req_sel1`, input, SEL_W: op code, 0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=SLT 6=SLTU 7=SLL 8=SRL 9=SRA.
- `rsp_valid0` / `rsp_valid1`, output, 1: response slot i holds a result.
- `rsp_ready0` / `rsp_ready1`, input, 1: requester i consumes the response this cycle.
- `rsp_result0` / `rsp_result1`, output, XLEN: registered ALU result.
- `rsp_zero0` / `rsp_zero1`, output, 1: registered `result == 0`.

## Operation
- Eligibility: requester i is eligible when `req_valid_i && (!rsp_valid_i || rsp_ready_i)`. A slot may be refilled in the same cycle it drains.
- Grant: at most one grant per cycle, so `req_ready_i = grant_i`.
  - One eligible requester: it wins.
  - Both eligible: the requester not recorded in `last_grant` wins.
- `last_grant` updates only on a cycle that issues a grant.
- The granted requester's a/b/sel drive the shared ALU combinationally.
- Result and zero are captured into slot i at the clock edge; `rsp_valid_i` is set.
- Slot clear: `rsp_valid_i` clears on `rsp_valid_i && rsp_ready_i && !grant_i`. It stays set and is overwritten with the new result on a simultaneous drain and grant.
- A slot holds result and zero stable while `rsp_valid_i && !rsp_ready_i`.
- Undefined sel codes 10–15 produce result 0 and zero 1. This is not an error.
- Arithmetic is XLEN-bit wrap-around.
  - SLT: signed compare.
  - SLTU: unsigned compare.
  - SRA: sign-extends.
  - Result bits above bit 0 are 0 for SLT and SLTU.
- Protocol rule: requesters must not make `req_valid` depend on `req_ready`, and must hold a/b/sel stable while valid and not ready.

## Timing
- Reset values: `rsp_valid0/1`=0, `rsp_result0/1`=0, `rsp_zero0/1`=0, `last_grant`=1 (requester 0 wins the first conflict).
- `req_ready0/1` are 0 while `rst_n`=0.
- Latency: request accepted in cycle T gives `rsp_valid` high in T+1.
- Throughput: 1 op/cycle total. Under continuous conflict, each requester gets 1 op per 2 cycles.
- Starvation bound: an eligible requester is granted within 2 cycles.
- Full slot: a requester with `rsp_valid=1` and `rsp_ready=0` is ineligible, so the other requester takes every cycle.
- Reset mid-operation: asserting `rst_n` discards any in-flight result immediately, with no clock edge needed. Outputs return to reset values. The first grant after deassertion follows the reset `last_grant`.
- There is no combinational path from `rsp_ready` to `rsp_result`/`rsp_zero`. The only combinational path from `rsp_ready` is to `req_ready`.

## Structure
- Shared package `alu_pkg` holds `XLEN`, `SEL_W`, op-code constants `ALU_ADD`…`ALU_SRA`, and `ALU_NUM_OPS`=10. These are reused by decode and by `alu`.
- One sub-module: the existing `alu`, instanced once; its zero output is used for `rsp_zero`.
- Arbiter grant logic and the two response slots live in `alu_arbiter`. A 2-way round-robin does not justify a separate module.

## Test plan
- Single op: `req_valid0`=1, a=10, b=20, sel=ADD in cycle T. Expect `req_ready0`=1 in T; `rsp_valid0`=1, result=30, zero=0 in T+1.
- Conflict after reset:
  - Both valid in T0: req0 SUB 20−10, req1 AND 0xF0F0&0x0FF0.
  - T0: grant0. T1: grant1.
  - T1: `rsp_result0`=10. T2: `rsp_result1`=0x00F0.
  - Continuous both-valid thereafter alternates grants 0,1,0,1.
- Backpressure:
  - req0 result pending with `rsp_ready0`=0 for 3 cycles while req0 keeps a new op valid. Expect `req_ready0`=0 and the result held for those 3 cycles; req1 is granted every cycle.
  - On `rsp_ready0`=1 with a new op, same-cycle refill: `rsp_valid0` stays 1 with the new value.
- Signed/unsigned/shift ops:
  - a=−5, b=3 SLT → 1; SLTU → 0.
  - a=1, b=4 SLL → 0x10.
  - a=0xF0, b=4 SRL → 0xF.
  - a=−16, b=2 SRA → −4.
  - 5−5 SUB → result 0, zero=1.
  - sel=12 → result 0, zero=1.
- Reset mid-op: grant req1 and assert `rst_n`=0 before the next edge. Expect `rsp_valid1`=0 immediately and `req_ready`=0 during reset. After release with both valid, grant0 comes first.
